// File: rtl/uart_msg_arbiter_pkg.sv
// Shared FSM state type and default sizing for the UART message arbiter.
package uart_msg_arbiter_pkg;

   localparam int unsigned DEF_N_REQ    = 32'd4;
   localparam int unsigned DEF_ADDR_W   = 32'd4;
   localparam int unsigned DEF_DATA_W   = 32'd8;
   localparam int unsigned DEF_START_TO = 32'd64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARB     = 3'd1,
      FETCH   = 3'd2,
      CHECK   = 3'd3,
      START   = 3'd4,
      WAIT_TX = 3'd5,
      DONE    = 3'd6
   } state_t;

endpackage

// File: rtl/uart_msg_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and index of the first
// requester after ptr, with ptr itself searched last.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand_s;
   logic             hit_s;

   // Walk ptr+1 .. ptr+N (mod N); the first hit masks all later candidates.
   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      cand_s = '0;
      hit_s  = 1'b0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand_s        = IDX_W'((32'(ptr) + i) % N);
         hit_s         = req[cand_s] & ~any;
         grant[cand_s] = grant[cand_s] | hit_s;
         idx           = hit_s ? cand_s : idx;
         any           = any | hit_s;
      end
   end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Shares one UART transmitter and the message ROM among N_REQ requesters,
// sending one null-terminated string per grant in round-robin order.
module uart_msg_arbiter
   import uart_msg_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ    = DEF_N_REQ,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned START_TO = DEF_START_TO
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*ADDR_W-1:0]   base_addr_i,
   output logic [N_REQ-1:0]          grant_o,
   output logic [N_REQ-1:0]          done_o,
   output logic                      err_o,
   output logic [ADDR_W-1:0]         addr_o,
   input  logic [DATA_W-1:0]         data_i,
   output logic                      start_o,
   input  logic                      busy_i,
   output logic                      active_o
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned TO_W  = $clog2(START_TO + 1);
   localparam logic [CNT_W-1:0] BYTE_LIMIT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(START_TO - 1);
   localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(N_REQ - 1);

   state_t            state_r;
   logic [IDX_W-1:0]  ptr_r;
   logic [IDX_W-1:0]  owner_r;
   logic [CNT_W-1:0]  byte_cnt_r;
   logic [TO_W-1:0]   to_cnt_r;
   logic              busy_meta_r;
   logic              busy_sync_r;
   logic [N_REQ-1:0]  arb_grant_s;
   logic [IDX_W-1:0]  arb_idx_s;
   logic              arb_any_s;
   logic [ADDR_W-1:0] base_sel_s;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req   (req_i),
      .ptr   (ptr_r),
      .grant (arb_grant_s),
      .idx   (arb_idx_s),
      .any   (arb_any_s)
   );

   // Base address slice belonging to the requester the arbiter selects.
   always_comb begin
      base_sel_s = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         base_sel_s = (arb_idx_s == IDX_W'(k)) ? base_addr_i[k*ADDR_W +: ADDR_W] : base_sel_s;
      end
   end

   // Two-flop synchronizer for busy_i, which lives in the UART clock domain.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_meta_r <= 1'b0;
         busy_sync_r <= 1'b0;
      end else begin
         busy_meta_r <= busy_i;
         busy_sync_r <= busy_meta_r;
      end
   end

   // Message sequencer: arbitration, ROM fetch and UART start/busy handshake.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r    <= IDLE;
         ptr_r      <= PTR_RST;
         owner_r    <= '0;
         byte_cnt_r <= '0;
         to_cnt_r   <= '0;
         grant_o    <= '0;
         done_o     <= '0;
         err_o      <= 1'b0;
         addr_o     <= '0;
         start_o    <= 1'b0;
         active_o   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= (|req_i) ? ARB : IDLE;
            end
            ARB: begin
               if (arb_any_s) begin
                  grant_o    <= arb_grant_s;
                  owner_r    <= arb_idx_s;
                  addr_o     <= base_sel_s;
                  active_o   <= 1'b1;
                  byte_cnt_r <= '0;
                  state_r    <= FETCH;
               end else begin
                  state_r    <= IDLE;
               end
            end
            FETCH: begin
               state_r <= CHECK;
            end
            CHECK: begin
               if (data_i == '0) begin
                  done_o  <= grant_o;
                  err_o   <= 1'b0;
                  state_r <= DONE;
               end else if (byte_cnt_r == BYTE_LIMIT) begin
                  // Whole ROM walked without a terminator.
                  done_o  <= grant_o;
                  err_o   <= 1'b1;
                  state_r <= DONE;
               end else begin
                  start_o  <= 1'b1;
                  to_cnt_r <= '0;
                  state_r  <= START;
               end
            end
            START: begin
               if (busy_sync_r) begin
                  start_o <= 1'b0;
                  state_r <= WAIT_TX;
               end else if (to_cnt_r == TO_LAST) begin
                  start_o <= 1'b0;
                  done_o  <= grant_o;
                  err_o   <= 1'b1;
                  state_r <= DONE;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1'b1);
               end
            end
            WAIT_TX: begin
               if (!busy_sync_r) begin
                  addr_o     <= addr_o + ADDR_W'(1'b1);
                  byte_cnt_r <= byte_cnt_r + CNT_W'(1'b1);
                  state_r    <= FETCH;
               end else begin
                  state_r    <= WAIT_TX;
               end
            end
            DONE: begin
               done_o   <= '0;
               err_o    <= 1'b0;
               grant_o  <= '0;
               active_o <= 1'b0;
               ptr_r    <= owner_r;
               state_r  <= IDLE;
            end
            default: begin
               done_o   <= '0;
               err_o    <= 1'b0;
               grant_o  <= '0;
               active_o <= 1'b0;
               start_o  <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: ROM and UART models, directed
// table vectors, multi-cycle corner sequences and a randomized model check.
module tb_uart_msg_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_i;
   logic [15:0] base_addr_i;
   logic [3:0]  grant_o;
   logic [3:0]  done_o;
   logic        err_o;
   logic [3:0]  addr_o;
   logic [7:0]  data_i;
   logic        start_o;
   logic        busy_i = 1'b0;
   logic        active_o;

   uart_msg_arbiter #(
      .N_REQ(4), .ADDR_W(4), .DATA_W(8), .START_TO(64)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .base_addr_i(base_addr_i),
      .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .addr_o(addr_o),
      .data_i(data_i), .start_o(start_o), .busy_i(busy_i), .active_o(active_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronous ROM model.
   logic [7:0] rom [16];
   always @(posedge clk) data_i <= rom[addr_o];

   // UART model: sees start, busy rises 3 cycles later and stays 10 cycles.
   logic       uart_stuck = 1'b0;
   int         u_dly = 0;
   int         u_busy = 0;
   logic [7:0] got_q [$];
   always @(posedge clk) begin
      if (u_busy > 0) begin
         u_busy <= u_busy - 1;
         busy_i <= (u_busy > 1);
      end else if (u_dly > 0) begin
         u_dly <= u_dly - 1;
         if (u_dly == 1) begin
            busy_i <= 1'b1;
            u_busy <= 10;
         end
      end else if (start_o && !uart_stuck) begin
         got_q.push_back(data_i);
         u_dly <= 2;
      end
   end

   // Message log built from done pulses.
   typedef struct {
      logic [3:0] done;
      logic       err;
      int         bidx;
      int         nbytes;
      int         nstarts;
   } msg_t;
   msg_t log_q [$];
   int   mark = 0;
   int   cur_starts = 0;
   int   viol = 0;
   logic start_prev = 1'b0;
   always @(negedge clk) begin
      start_prev <= start_o;
      if (!rst_n) begin
         cur_starts <= 0;
         mark       <= got_q.size();
      end else if (done_o != 4'b0) begin
         log_q.push_back('{done_o, err_o, mark, got_q.size() - mark, cur_starts});
         cur_starts <= 0;
         mark       <= got_q.size();
      end else if (start_o && !start_prev) begin
         cur_starts <= cur_starts + 1;
      end
      if (!$onehot0(grant_o) || (start_o && !active_o)) viol <= viol + 1;
   end

   // Reference model: round-robin order plus the string each owner should get.
   int mptr = 3;
   task automatic expect_msgs(input logic [3:0] mask, input logic [15:0] bases, input int lstart);
      logic [3:0] pend;
      logic [3:0] bv;
      logic [7:0] b;
      logic [7:0] exp_b [$];
      logic       e;
      int         li;
      int         o;
      int         k2;
      pend = mask;
      li   = lstart;
      while (pend != 4'b0) begin
         o = 0;
         for (int s = 4; s >= 1; s--) begin
            k2 = (mptr + s) % 4;
            if (((pend >> k2) & 4'b1) != 4'b0) o = k2;
         end
         bv = bases[4*o +: 4];
         exp_b.delete();
         e = 1'b1;
         for (int i = 0; i < 16; i++) begin
            b = rom[4'(bv + i)];
            if (b == 8'h00) begin
               e = 1'b0;
               break;
            end
            exp_b.push_back(b);
         end
         if (li >= log_q.size()) begin
            check("msg_missing", log_q.size(), li + 1);
            return;
         end
         check("owner", log_q[li].done, 4'b1 << o);
         check("err", log_q[li].err, e);
         check("nbytes", log_q[li].nbytes, exp_b.size());
         check("nstarts", log_q[li].nstarts, exp_b.size());
         for (int i = 0; i < exp_b.size() && i < log_q[li].nbytes; i++)
            check("byte", got_q[log_q[li].bidx + i], exp_b[i]);
         pend = pend & ~(4'b1 << o);
         mptr = o;
         li++;
      end
      check("msg_count", log_q.size(), li);
   endtask

   // Apply a request mask; each requester drops its request at its done pulse.
   task automatic serve(input logic [3:0] mask, input logic [15:0] bases, input int budget);
      int cyc;
      base_addr_i = bases;
      req_i = mask;
      cyc = 0;
      while (req_i != 4'b0 && cyc < budget) begin
         @(negedge clk);
         req_i = req_i & ~done_o;
         cyc++;
      end
      check("serve_complete", req_i, 4'b0);
      req_i = 4'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_i = 4'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mptr = 3;
      @(negedge clk);
   endtask

   task automatic init_rom_table();
      rom = '{8'h48, 8'h69, 8'h00, 8'h55, 8'h41, 8'h00, 8'h42, 8'h00,
              8'h31, 8'h32, 8'h00, 8'h33, 8'h34, 8'h35, 8'h00, 8'h36};
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [15:0] bases;
      int          nmsg;
      logic [7:0]  order;
      int          nbytes;
   } vec_t;
   vec_t vt [5];

   int         ls, bs, gcyc, dcyc, shi, n;
   logic [3:0] dm;
   logic       de, seen;
   logic [3:0] seq [4];
   logic [1:0] ow;
   logic [3:0] mask;
   logic [15:0] bases;

   initial begin
      vt[0] = '{4'b0001, 16'h0000, 1, 8'h00, 2};
      vt[1] = '{4'b0110, 16'h0400, 2, 8'h09, 3};
      vt[2] = '{4'b1000, 16'h7000, 1, 8'h03, 0};
      vt[3] = '{4'b1111, 16'h28FB, 4, 8'hE4, 8};
      vt[4] = '{4'b1010, 16'hD060, 2, 8'h0D, 2};

      rst_n = 1'b0;
      req_i = 4'b0;
      base_addr_i = 16'h0;
      init_rom_table();
      repeat (2) @(negedge clk);
      check("rst_grant", grant_o, 4'b0);
      check("rst_done", done_o, 4'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_start", start_o, 1'b0);
      check("rst_addr", addr_o, 4'h0);
      check("rst_active", active_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table: order and byte totals from a fresh reset.
      for (int t = 0; t < 5; t++) begin
         do_reset();
         ls = log_q.size();
         bs = got_q.size();
         serve(vt[t].req, vt[t].bases, 2000);
         check("tbl_nmsg", log_q.size() - ls, vt[t].nmsg);
         for (int j = 0; j < vt[t].nmsg && ls + j < log_q.size(); j++) begin
            ow = vt[t].order[2*j +: 2];
            check("tbl_owner", log_q[ls+j].done, 4'b1 << ow);
            check("tbl_err", log_q[ls+j].err, 1'b0);
         end
         check("tbl_bytes", got_q.size() - bs, vt[t].nbytes);
      end

      // Latency: grant 2 cycles, empty string done 4 cycles after request.
      do_reset();
      base_addr_i = 16'h7000;
      req_i = 4'b1000;
      gcyc = 0;
      dcyc = 0;
      dm = 4'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (gcyc == 0 && grant_o != 4'b0) gcyc = c;
         if (done_o != 4'b0) begin
            dcyc = c;
            dm = done_o;
            req_i = 4'b0;
            break;
         end
      end
      check("grant_latency", gcyc, 2);
      check("empty_done_latency", dcyc, 4);
      check("empty_done_mask", dm, 4'b1000);
      repeat (2) @(negedge clk);
      check("empty_nstarts", (log_q.size() > 0) ? log_q[log_q.size()-1].nstarts : -1, 0);
      check("empty_idle_active", active_o, 1'b0);

      // Start timeout with busy stuck low.
      do_reset();
      uart_stuck = 1'b1;
      base_addr_i = 16'h0000;
      req_i = 4'b0001;
      shi = 0;
      dm = 4'b0;
      de = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (start_o) shi++;
         if (done_o != 4'b0) begin
            dm = done_o;
            de = err_o;
            req_i = 4'b0;
            break;
         end
      end
      check("to_start_cycles", shi, 64);
      check("to_done", dm, 4'b0001);
      check("to_err", de, 1'b1);
      repeat (2) @(negedge clk);
      check("to_idle_active", active_o, 1'b0);
      check("to_nstarts", (log_q.size() > 0) ? log_q[log_q.size()-1].nstarts : -1, 1);
      uart_stuck = 1'b0;
      mptr = 0;

      // No terminator anywhere: 16 bytes with address wrap, then error.
      for (int i = 0; i < 16; i++) rom[i] = 8'h80 + 8'(i);
      repeat (20) @(negedge clk);
      ls = log_q.size();
      serve(4'b0001, 16'h0005, 2000);
      expect_msgs(4'b0001, 16'h0005, ls);

      // Re-serve only when nobody else is pending.
      init_rom_table();
      do_reset();
      base_addr_i = 16'h0096;
      req_i = 4'b0011;
      n = 0;
      for (int i = 0; i < 4; i++) seq[i] = 4'b0;
      for (int c = 0; c < 600 && n < 4; c++) begin
         @(negedge clk);
         if (done_o != 4'b0) begin
            seq[n] = done_o;
            n++;
            if (n == 2) req_i[1] = 1'b0;
         end
      end
      req_i = 4'b0;
      check("rr_seq0", seq[0], 4'b0001);
      check("rr_seq1", seq[1], 4'b0010);
      check("rr_seq2", seq[2], 4'b0001);
      check("rr_seq3", seq[3], 4'b0001);
      repeat (3) @(negedge clk);

      // Reset mid-message: phase 0 in START, phase 1 in WAIT_TX.
      for (int ph = 0; ph < 2; ph++) begin
         repeat (20) @(negedge clk);
         base_addr_i = 16'h0000;
         req_i = 4'b0001;
         seen = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (start_o) seen = 1'b1;
            if (ph == 0 && seen) break;
            if (ph == 1 && seen && !start_o) break;
         end
         check("mid_reached", seen, 1'b1);
         #2 rst_n = 1'b0;
         #1;
         check("mid_rst_start", start_o, 1'b0);
         check("mid_rst_grant", grant_o, 4'b0);
         check("mid_rst_active", active_o, 1'b0);
         req_i = 4'b0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         mptr = 3;
         repeat (20) @(negedge clk);
         ls = log_q.size();
         serve(4'b0001, 16'h0000, 2000);
         expect_msgs(4'b0001, 16'h0000, ls);
      end

      // Randomized ROM contents, masks and bases against the model.
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 16; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         mask  = 4'($urandom_range(1, 15));
         bases = 16'($urandom);
         ls = log_q.size();
         serve(mask, bases, 6000);
         expect_msgs(mask, bases, ls);
      end

      check("grant_onehot_start_scope", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
